// File: rtl/prog_loader_if.sv
// Load-stream interface for prog_loader.
// A producer (master) drives a start pulse with a word count, then streams
// instruction words over a valid/ready handshake. The loader (slave) answers with ld_ready.
// Signals:
//   ld_start  master->slave  one-cycle pulse, begin a load of ld_count words
//   ld_count  master->slave  number of words to load, sampled with ld_start
//   ld_valid  master->slave  ld_data carries a word
//   ld_data   master->slave  instruction word
//   ld_ready  slave->master  loader accepts a word this cycle
//   ld_csum   master->slave  expected XOR of all words, sampled with ld_start
//                            (only when PROG_LOADER_CHECKSUM_EN is defined)
interface prog_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              ld_start;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] ld_csum;
`endif

    modport master (
        output ld_start,
        output ld_count,
        output ld_valid,
        output ld_data,
`ifdef PROG_LOADER_CHECKSUM_EN
        output ld_csum,
`endif
        input  ld_ready
    );

    modport slave (
        input  ld_start,
        input  ld_count,
        input  ld_valid,
        input  ld_data,
`ifdef PROG_LOADER_CHECKSUM_EN
        input  ld_csum,
`endif
        output ld_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader and instruction store for the riscv core.
// Accepts a word stream over the ld interface, writes it into an internal instruction
// memory while holding the core in reset, then releases the core and serves fetches.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (XOR integrity check of the stream).
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   ld         prog_loader_if.slave load stream (start/count/valid/data/ready[/csum])
//   core_reset reset to the riscv core; high whenever not running
//   done       program loaded and core released
//   err        sticky error (bad count or checksum); cleared only by reset
//   rd_addr    core fetch byte address
//   rd_data    fetched instruction (combinational; 0 beyond the memory)
module prog_loader #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned ADDR_W         = $clog2(DEPTH),
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      ld,
    output logic              core_reset,
    output logic              done,
    output logic              err,
    input  logic [31:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned HoldW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StHold, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [HoldW-1:0]  hold_q;
    logic              ld_ready_q;
    logic              core_reset_q;
    logic              done_q;
    logic              err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    logic [DATA_W-1:0] xor_q;
    logic [DATA_W-1:0] xor_next;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic            count_ok;
    logic            xfer;
    logic            last_xfer;
    logic [ADDR_W:0] count_m1;

    assign count_ok  = (ld.ld_count != '0) && (ld.ld_count <= DepthCnt);
    assign xfer      = (state_q == StLoad) && ld.ld_valid && ld_ready_q;
    assign count_m1  = count_q - 1'b1;
    assign last_xfer = xfer && ({1'b0, ptr_q} == count_m1);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign xor_next  = xor_q ^ ld.ld_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            ld_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
            xor_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    // A start from RUN is a reload; a bad count never disturbs the state.
                    if (ld.ld_start) begin
                        if (!count_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            count_q      <= ld.ld_count;
                            ptr_q        <= '0;
                            ld_ready_q   <= 1'b1;
                            core_reset_q <= 1'b1;
                            done_q       <= 1'b0;
                            state_q      <= StLoad;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum_q       <= ld.ld_csum;
                            xor_q        <= '0;
`endif
                        end
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        ptr_q <= ptr_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_q <= xor_next;
`endif
                        if (last_xfer) begin
                            ld_ready_q <= 1'b0;
                            hold_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            if (xor_next != csum_q) begin
                                err_q   <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StHold;
                            end
`else
                            state_q    <= StHold;
`endif
                        end
                    end
                end
                StHold: begin
                    if (hold_q == HoldLast) begin
                        core_reset_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= StRun;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Instruction memory is not reset; contents survive reset and partial reloads.
    always_ff @(posedge clk) begin
        if (!reset && xfer) begin
            mem_q[ptr_q] <= ld.ld_data;
        end
    end

    // Fetch path: byte address to word index, out-of-range words read as 0.
    logic [29:0] word_idx;
    logic        unused_addr_bits;

    assign word_idx         = rd_addr[31:2];
    assign unused_addr_bits = ^rd_addr[1:0];

    always_comb begin
        rd_data = '0;
        if (word_idx < 30'(DEPTH)) begin
            rd_data = mem_q[word_idx[ADDR_W-1:0]];
        end
    end

    assign ld.ld_ready = ld_ready_q;
    assign core_reset  = core_reset_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
